reg_bank: RTL and testbench

Parametrised register bank behind the SPI register-access slave, in the normal clock domain. Provides version/config identification, a control register, self-clearing pulse bits, sticky event status with write-1-to-clear and a masked interrupt, a 16-bit free-running counter with atomic two-byte read, and `NUM_SCRATCH` scratchpad registers. Connects directly to the slave's `regnum`/`regdata_read`/`regdata_write`/`read`/`write` signals.

---
 rtl/reg_bank.sv | 124 ++++++++++++
 tb/tb_reg_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank behind the SPI register-access slave: identification, control, pulse bits,
// sticky W1C event status with masked interrupt, free-running counter and scratchpad registers.
module reg_bank #(
  parameter logic [7:0]  VERSION       = 8'h18,
  parameter int unsigned NUM_SCRATCH   = 4,
  parameter logic [7:0]  SCRATCH_RESET = 8'h73,
  parameter logic [7:0]  CTRL_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] regnum,
  input  logic [7:0] regdata_write,
  input  logic       write,
  input  logic       read,
  output logic [7:0] regdata_read,
  input  logic [7:0] event_in,
  output logic [7:0] ctrl_out,
  output logic [7:0] pulse_out,
  output logic       irq
);

  localparam logic [6:0]  AddrVersion = 7'd0;
  localparam logic [6:0]  AddrConfig  = 7'd1;
  localparam logic [6:0]  AddrCtrl    = 7'd2;
  localparam logic [6:0]  AddrPulse   = 7'd3;
  localparam logic [6:0]  AddrStatus  = 7'd4;
  localparam logic [6:0]  AddrMask    = 7'd5;
  localparam logic [6:0]  AddrCntLo   = 7'd6;
  localparam logic [6:0]  AddrCntHi   = 7'd7;
  localparam int unsigned ScratchBase = 8;

  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  mask_q, mask_d;
  logic        irq_q, irq_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  event_q;
  logic [7:0]  rise;
  logic [7:0]  scratch_q [NUM_SCRATCH];
  logic [7:0]  scratch_d [NUM_SCRATCH];

  always_comb begin
    rise     = event_in & ~event_q;
    ctrl_d   = ctrl_q;
    mask_d   = mask_q;
    pulse_d  = 8'h00;
    status_d = status_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q + 16'd1;
    irq_d    = |(status_q & mask_q);
    scratch_d = scratch_q;

    if (write) begin
      unique case (regnum)
        AddrCtrl:   ctrl_d   = regdata_write;
        AddrPulse:  pulse_d  = regdata_write;
        AddrStatus: status_d = status_q & ~regdata_write;
        AddrMask:   mask_d   = regdata_write;
        AddrCntLo:  cnt_d    = 16'h0000;
        default: begin
          for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (regnum == 7'(ScratchBase + i)) scratch_d[i] = regdata_write;
          end
        end
      endcase
    end

    // Applied after the clear so a simultaneous new edge keeps the bit set.
    status_d = status_d | rise;

    // Latch the high byte alongside the low-byte read for a coherent 16-bit sample.
    if (read && regnum == AddrCntLo) shadow_d = cnt_q[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= CTRL_RESET;
      pulse_q  <= 8'h00;
      status_q <= 8'h00;
      mask_q   <= 8'h00;
      irq_q    <= 1'b0;
      cnt_q    <= 16'h0000;
      shadow_q <= 8'h00;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= SCRATCH_RESET;
    end else begin
      ctrl_q   <= ctrl_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
    // Tracked through reset so a level held high across reset is not seen as an edge.
    event_q <= event_in;
  end

  always_comb begin
    regdata_read = 8'h00;
    unique case (regnum)
      AddrVersion: regdata_read = VERSION;
      AddrConfig:  regdata_read = 8'(NUM_SCRATCH);
      AddrCtrl:    regdata_read = ctrl_q;
      AddrPulse:   regdata_read = 8'h00;
      AddrStatus:  regdata_read = status_q;
      AddrMask:    regdata_read = mask_q;
      AddrCntLo:   regdata_read = cnt_q[7:0];
      AddrCntHi:   regdata_read = shadow_q;
      default: begin
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
          if (regnum == 7'(ScratchBase + i)) regdata_read = scratch_q[i];
        end
      end
    endcase
  end

  assign ctrl_out  = ctrl_q;
  assign pulse_out = pulse_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_reg_bank.sv
// Randomised scoreboard bench for reg_bank against a behavioural register-map model.
module tb_reg_bank;

  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] regnum = '0;
  logic [7:0] regdata_write = '0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] regdata_read;
  logic [7:0] event_in = '0;
  logic [7:0] ctrl_out;
  logic [7:0] pulse_out;
  logic       irq;

  always #5 clk = ~clk;

  reg_bank #(
    .VERSION      (8'h18),
    .NUM_SCRATCH  (NS),
    .SCRATCH_RESET(8'h73),
    .CTRL_RESET   (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .regnum       (regnum),
    .regdata_write(regdata_write),
    .write        (write),
    .read         (read),
    .regdata_read (regdata_read),
    .event_in     (event_in),
    .ctrl_out     (ctrl_out),
    .pulse_out    (pulse_out),
    .irq          (irq)
  );

  typedef struct {
    logic [7:0] rd;
    logic [7:0] ctrl;
    logic [7:0] pulse;
    logic       irq;
    int         addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: register contents as plain integers.
  int m_ctrl, m_pulse, m_status, m_mask, m_irq, m_cnt, m_shadow, m_evq;
  int m_scr[NS];

  function automatic int exp_rd(int a);
    if (a == 0) return 'h18;
    if (a == 1) return NS;
    if (a == 2) return m_ctrl;
    if (a == 4) return m_status;
    if (a == 5) return m_mask;
    if (a == 6) return m_cnt % 256;
    if (a == 7) return m_shadow;
    if (a >= 8 && a < 8 + NS) return m_scr[a - 8];
    return 0;
  endfunction

  function automatic void model_reset(int ev);
    m_ctrl = 0; m_pulse = 0; m_status = 0; m_mask = 0; m_irq = 0;
    m_cnt = 0; m_shadow = 0; m_evq = ev;
    for (int i = 0; i < NS; i++) m_scr[i] = 'h73;
  endfunction

  function automatic void model_step(bit r, bit w, bit rd, int a, int d, int ev);
    int rise, next_irq;
    if (r) begin
      model_reset(ev);
      return;
    end
    rise     = ev & ~m_evq & 'hFF;
    next_irq = ((m_status & m_mask) != 0) ? 1 : 0;
    m_pulse  = (w && a == 3) ? d : 0;
    if (rd && a == 6) m_shadow = m_cnt / 256;
    m_cnt = (w && a == 6) ? 0 : (m_cnt + 1) % 65536;
    if (w && a == 4) m_status = m_status & ~d & 'hFF;
    m_status = m_status | rise;
    if (w && a == 2) m_ctrl = d;
    if (w && a == 5) m_mask = d;
    if (w && a >= 8 && a < 8 + NS) m_scr[a - 8] = d;
    m_irq = next_irq;
    m_evq = ev;
  endfunction

  task automatic step(bit r, bit w, bit rd, int a, int d, int ev);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; write = w; read = rd;
    regnum = 7'(a); regdata_write = 8'(d); event_in = 8'(ev);
    e.rd = 8'(exp_rd(a)); e.ctrl = 8'(m_ctrl); e.pulse = 8'(m_pulse);
    e.irq = (m_irq != 0); e.addr = a;
    exp_q.push_back(e);
    model_step(r, w, rd, a, d, ev);
  endtask

  task automatic check(string name, int addr, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s addr=%0d at %0t: got %h expected %h", name, addr, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("regdata_read", e.addr, regdata_read, e.rd);
      check("ctrl_out", e.addr, ctrl_out, e.ctrl);
      check("pulse_out", e.addr, pulse_out, e.pulse);
      check("irq", e.addr, {7'd0, irq}, {7'd0, e.irq});
    end
  end

  int ev_lvl;

  initial begin
    // First edge clears the DUT's unknown power-up state; checking starts afterwards.
    @(posedge clk);
    #1;
    model_reset(0);

    // Reset contents
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 8, 0, 0);
    step(0, 0, 1, 8 + NS, 0, 0);

    // RW registers and an unmapped address
    step(0, 1, 0, 2, 'hA5, 0);
    step(0, 0, 1, 2, 0, 0);
    for (int i = 0; i < NS; i++) begin
      step(0, 1, 0, 8 + i, 'hA5, 0);
      step(0, 0, 1, 8 + i, 0, 0);
    end
    step(0, 1, 0, 127, 'hA5, 0);
    step(0, 0, 1, 127, 0, 0);

    // Pulse bits, including back-to-back writes
    step(0, 1, 0, 3, 'h81, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 1, 0, 3, 'h0F, 0);
    step(0, 1, 0, 3, 'hF0, 0);
    step(0, 0, 0, 3, 0, 0);
    step(0, 0, 0, 3, 0, 0);

    // Status, W1C with simultaneous set, and interrupt
    step(0, 1, 0, 5, 'h04, 0);
    step(0, 0, 0, 4, 0, 'h04);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 1, 0, 4, 'h04, 'h04);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 1, 0, 4, 'h04, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 4, 0, 0);

    // Counter with coherent two-byte read across a low-byte carry
    step(0, 1, 0, 6, 'h00, 0);
    for (int i = 0; i < 'h1FF; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 6, 0, 0);
    step(0, 0, 0, 6, 0, 0);
    step(0, 0, 0, 6, 0, 0);
    step(0, 0, 1, 7, 0, 0);

    // Event level held through reset, reset overriding a CTRL write
    step(0, 0, 0, 4, 0, 0);
    step(1, 1, 0, 2, 'h5A, 'hFF);
    step(1, 0, 0, 4, 0, 'hFF);
    step(0, 0, 1, 4, 0, 'hFF);
    step(0, 0, 1, 2, 0, 'hFF);

    // Randomised traffic
    ev_lvl = 'hFF;
    for (int i = 0; i < 3000; i++) begin
      int a, d;
      bit r, w, rd;
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                       : int'($urandom_range(0, 8 + NS));
      d  = int'($urandom_range(0, 255));
      w  = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 199) == 0);
      ev_lvl = ev_lvl ^ int'(($urandom & $urandom & $urandom) & 32'hFF);
      step(r, w, rd, a, d, ev_lvl);
    end

    step(0, 0, 0, 0, 0, ev_lvl);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
